// File: rtl/fibo_controller.sv
// -----------------------------------------------------------------------------
// fibo_controller
//   Sequencer that drives a purely combinational ALU to compute the Fibonacci
//   number F(n). It owns the operand registers (A, B, CNT), the sticky wrap
//   flags, and the FSM. On every cycle it drives an opcode and operands to the
//   ALU, and it samples alu_out/alu_zero in that same cycle.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : computation request, sampled only in IDLE
//   n          : Fibonacci index, captured when start is accepted
//   alu_out    : ALU result
//   alu_zero   : ALU zero flag
//   alu_in1    : ALU operand 1
//   alu_in2    : ALU operand 2
//   alu_opcode : ALU opcode
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse while the result is valid
//   result     : F(n) mod 2^SIZE, held until the next run completes
//   overflow   : true F(n) did not fit in SIZE bits, held with result
// -----------------------------------------------------------------------------
module fibo_controller #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [SIZE-1:0] n,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero,
    output logic [SIZE-1:0] alu_in1,
    output logic [SIZE-1:0] alu_in2,
    output logic [SIZE-2:0] alu_opcode,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result,
    output logic            overflow
);

    localparam logic [SIZE-2:0] OP_NOP   = 3'b000;
    localparam logic [SIZE-2:0] OP_ONE   = 3'b001;
    localparam logic [SIZE-2:0] OP_DEC   = 3'b011;
    localparam logic [SIZE-2:0] OP_PASS  = 3'b100;
    localparam logic [SIZE-2:0] OP_ADD   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_DEC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            a_ovf_q, a_ovf_d;
    logic            b_ovf_q, b_ovf_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            overflow_q, overflow_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            a_ovf_q    <= 1'b0;
            b_ovf_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            a_ovf_q    <= a_ovf_d;
            b_ovf_q    <= b_ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        a_ovf_d    = a_ovf_q;
        b_ovf_d    = b_ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        alu_opcode = OP_NOP;
        alu_in1    = '0;
        alu_in2    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = n;
                    a_d     = '0;
                    b_d     = '0;
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                // The ALU produces the constant 1 here, seeding B = F(1).
                alu_opcode = OP_ONE;
                b_d        = alu_out;
                state_d    = S_CHECK;
            end
            S_CHECK: begin
                alu_opcode = OP_PASS;
                alu_in1    = cnt_q;
                if (alu_zero) begin
                    result_d   = a_q;
                    overflow_d = a_ovf_q;
                    state_d    = S_DONE;
                end else begin
                    state_d    = S_ADD;
                end
            end
            S_ADD: begin
                alu_opcode = OP_ADD;
                alu_in1    = a_q;
                alu_in2    = b_q;
                a_d        = b_q;
                a_ovf_d    = b_ovf_q;
                b_d        = alu_out;
                // A wrapped sum is smaller than either addend, which flags the carry-out.
                b_ovf_d    = b_ovf_q | (alu_out < b_q);
                state_d    = S_DEC;
            end
            S_DEC: begin
                // CNT is non-zero here, so the decrement never wraps.
                alu_opcode = OP_DEC;
                alu_in1    = cnt_q;
                cnt_d      = alu_out;
                state_d    = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fibo_controller.sv
module tb_fibo_controller;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] n;
    logic [3:0] alu_out;
    logic       alu_zero;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [2:0] alu_opcode;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int ops[$];

    fibo_controller #(.SIZE(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .n          (n),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational 4-bit ALU model
    always_comb begin
        case (alu_opcode)
            3'b001:  alu_out = alu_in1 + 4'd1;
            3'b011:  alu_out = alu_in1 - 4'd1;
            3'b100:  alu_out = alu_in1;
            3'b110:  alu_out = alu_in1 + alu_in2;
            default: alu_out = 4'd0;
        endcase
        alu_zero = (alu_out == 4'd0);
    end

    function automatic int fib(input int k);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch a run and wait (bounded) for done. cyc counts edges after the start edge.
    task automatic run(input int nv, input bit pulse_dec, output int cyc);
        bit pulsed;
        pulsed = 1'b0;
        ops.delete();
        @(negedge clk);
        start = 1'b1;
        n     = 4'(nv);
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 200) begin
            if (pulse_dec && alu_opcode == 3'b011 && !pulsed) begin
                start  = 1'b1;
                n      = 4'($urandom);
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            ops.push_back(int'(alu_opcode));
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input int nv, input bit pulse_dec);
        int cyc;
        int f;
        run(nv, pulse_dec, cyc);
        f = fib(nv);
        check({tag, "_latency"}, cyc, 2 + 3 * nv);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_done"}, int'(busy), 1);
        check({tag, "_result"}, int'(result), f % 16);
        check({tag, "_overflow"}, int'(overflow), (f > 15) ? 1 : 0);
        @(negedge clk);
        check({tag, "_done_off"}, int'(done), 0);
        check({tag, "_busy_off"}, int'(busy), 0);
        check({tag, "_result_hold"}, int'(result), f % 16);
    endtask

    initial begin
        int cyc;
        int gap;
        int exp_ops[$];

        reset_n = 1'b0;
        start   = 1'b0;
        n       = 4'd0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_opcode", int'(alu_opcode), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_check("n0", 0, 1'b0);
        run_check("n1", 1, 1'b0);
        exp_ops.delete();
        exp_ops.push_back(1);
        for (int i = 0; i < 1; i++) begin
            exp_ops.push_back(4);
            exp_ops.push_back(6);
            exp_ops.push_back(3);
        end
        exp_ops.push_back(4);
        check("n1_op_count", ops.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < ops.size(); i++)
            check($sformatf("n1_op%0d", i), ops[i], exp_ops[i]);
        run_check("n7", 7, 1'b0);
        run_check("n8", 8, 1'b0);
        run_check("n15", 15, 1'b0);

        // Start held high: exactly one run, next accepted in the IDLE cycle after DONE
        @(negedge clk);
        start = 1'b1;
        n     = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("hold_latency", cyc, 11);
        check("hold_result", int'(result), 2);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_gap", int'(busy), 0);
        gap = 1;
        while (!done && gap < 200) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_second_gap", gap, 13);
        check("hold_second_result", int'(result), 2);
        @(negedge clk);
        check("hold_stop", int'(busy), 0);

        // Start pulse (and n change) during DEC must not disturb the run
        run_check("decpulse", 4, 1'b1);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int nv;
            nv = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_check($sformatf("rnd%0d_n%0d", r, nv), nv, ($urandom_range(0, 1) == 1));
        end

        // Leave a non-zero result, then reset asynchronously mid-ADD of an n=6 run
        run_check("pre_rst", 7, 1'b0);
        @(negedge clk);
        start = 1'b1;
        n     = 4'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (alu_opcode != 3'b110 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_add_reached", int'(alu_opcode), 6);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_result", int'(result), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_opcode", int'(alu_opcode), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_resume", int'(busy), 0);
        run_check("after_rst_n5", 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
